// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: machine word and RAM handshake status.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

endpackage

// File: rtl/cache_mem_arbiter.sv
// Arbitrates one RAM port between instruction and data caches; a data block
// transfer of BURST_LEN beats holds the grant so icache reads cannot interleave.
module cache_mem_arbiter
   import cpu_types_pkg::*;
#(
   parameter int unsigned BURST_LEN = 2
) (
   input  logic      CLK,
   input  logic      RST,
   input  logic      iREN,
   input  word_t     iaddr,
   output logic      iwait,
   output word_t     iload,
   input  logic      dREN,
   input  logic      dWEN,
   input  word_t     daddr,
   input  word_t     dstore,
   output logic      dwait,
   output word_t     dload,
   output logic      ramREN,
   output logic      ramWEN,
   output word_t     ramaddr,
   output word_t     ramstore,
   input  word_t     ramload,
   input  ramstate_t ramstate,
   output logic      err
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DGRANT = 2'd1,
      IGRANT = 2'd2
   } state_t;

   localparam logic [1:0] LAST_BEAT = 2'(BURST_LEN - 1);

   state_t     state_q;
   logic [1:0] beat_q;
   logic       err_q;
   state_t     cur;
   logic       dreq;

   assign dreq = dREN | dWEN;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         beat_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         if (state_q != IDLE && ramstate == ERROR) begin
            err_q <= 1'b1;
         end
         case (state_q)
            IDLE: begin
               if (dreq) begin
                  state_q <= DGRANT;
               end else if (iREN) begin
                  state_q <= IGRANT;
               end
            end
            DGRANT: begin
               if (!dreq) begin
                  state_q <= IDLE;
                  beat_q  <= '0;
               end else if (ramstate == ACCESS) begin
                  if (beat_q == LAST_BEAT) begin
                     beat_q  <= '0;
                     state_q <= iREN ? IGRANT : IDLE;
                  end else begin
                     beat_q <= beat_q + 2'd1;
                  end
               end
            end
            IGRANT: begin
               if (!iREN) begin
                  state_q <= IDLE;
               end else if (ramstate == ACCESS) begin
                  // Hand over to a waiting dcache after each icache beat to avoid starvation.
                  state_q <= dreq ? DGRANT : IGRANT;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Reset forces the idle output set immediately, so a burst stops driving RAM this cycle.
   assign cur = RST ? IDLE : state_q;
   assign err = err_q;

   always_comb begin
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      iwait    = 1'b1;
      iload    = '0;
      dwait    = 1'b1;
      dload    = '0;
      case (cur)
         DGRANT: begin
            ramaddr  = daddr;
            ramstore = dstore;
            ramWEN   = dWEN;
            ramREN   = dREN & ~dWEN;
            dload    = ramload;
            dwait    = (ramstate != ACCESS);
         end
         IGRANT: begin
            ramREN  = iREN;
            ramaddr = iaddr;
            iload   = ramload;
            iwait   = (ramstate != ACCESS);
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Randomised and directed checks of cache_mem_arbiter against an ownership/beat-count model.
module tb_cache_mem_arbiter;
   import cpu_types_pkg::*;

   localparam int BL = 2;

   logic      CLK = 1'b0;
   logic      RST;
   logic      iREN, dREN, dWEN;
   word_t     iaddr, daddr, dstore, ramload;
   ramstate_t ramstate;
   logic      iwait, dwait, ramREN, ramWEN, err;
   word_t     iload, dload, ramaddr, ramstore;

   int checks = 0;
   int passes = 0;

   // model: owner 0 = nobody, 1 = dcache, 2 = icache
   int m_owner = 0;
   int m_beats = 0;
   bit m_err   = 1'b0;

   typedef struct packed {
      logic  ren;
      logic  wen;
      word_t addr;
      word_t store;
      logic  iw;
      word_t il;
      logic  dw;
      word_t dl;
      logic  er;
   } outs_t;

   cache_mem_arbiter #(.BURST_LEN(BL)) dut (
      .CLK(CLK), .RST(RST),
      .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dwait(dwait), .dload(dload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate), .err(err)
   );

   always #5 CLK = ~CLK;

   function automatic outs_t dut_out();
      return '{ramREN, ramWEN, ramaddr, ramstore, iwait, iload, dwait, dload, err};
   endfunction

   function automatic outs_t model_out();
      outs_t o;
      o = '{1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'd0, 1'b1, 32'd0, m_err};
      if (!RST && m_owner == 1) begin
         o.addr  = daddr;
         o.store = dstore;
         o.wen   = dWEN;
         o.ren   = dREN && !dWEN;
         o.dl    = ramload;
         o.dw    = (ramstate != ACCESS);
      end else if (!RST && m_owner == 2) begin
         o.ren  = iREN;
         o.addr = iaddr;
         o.il   = ramload;
         o.iw   = (ramstate != ACCESS);
      end
      return o;
   endfunction

   task automatic model_clock();
      bit dq;
      dq = dREN || dWEN;
      if (RST) begin
         m_owner = 0; m_beats = 0; m_err = 1'b0;
      end else begin
         if (m_owner != 0 && ramstate == ERROR) m_err = 1'b1;
         if (m_owner == 0) begin
            if (dq) m_owner = 1;
            else if (iREN) m_owner = 2;
         end else if (m_owner == 1) begin
            if (!dq) begin
               m_owner = 0; m_beats = 0;
            end else if (ramstate == ACCESS) begin
               m_beats = m_beats + 1;
               if (m_beats == BL) begin
                  m_beats = 0;
                  m_owner = iREN ? 2 : 0;
               end
            end
         end else begin
            if (!iREN) m_owner = 0;
            else if (ramstate == ACCESS) m_owner = dq ? 1 : 2;
         end
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      model_clock();
      #1;
   endtask

   task automatic idle_inputs();
      iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
      iaddr = '0; daddr = '0; dstore = '0; ramload = '0;
      ramstate = FREE;
   endtask

   task automatic apply_reset();
      RST = 1'b1;
      tick();
      RST = 1'b0;
   endtask

   task automatic test_reset();
      outs_t exp;
      idle_inputs();
      RST = 1'b1;
      tick();
      dREN = 1'b1; iREN = 1'b1; dWEN = 1'b1; ramstate = ACCESS;
      daddr = 32'h1234; iaddr = 32'h5678; ramload = 32'hCAFE;
      @(negedge CLK);
      exp = model_out();
      checks++;
      if (dut_out() !== exp) $display("FAIL reset_hold got %h exp %h", dut_out(), exp);
      else passes++;
      tick();
      idle_inputs();
      RST = 1'b0;
      @(negedge CLK);
      exp = model_out();
      checks++;
      if (dut_out() !== exp) $display("FAIL reset_release got %h exp %h", dut_out(), exp);
      else passes++;
      tick();
   endtask

   task automatic test_dread_burst();
      outs_t exp;
      int zeros;
      bit beat;
      idle_inputs();
      dREN = 1'b1; daddr = 32'h100;
      zeros = 0;
      for (int c = 0; c < 10; c++) begin
         ramstate = (c % 2 == 1) ? ACCESS : BUSY;
         ramload  = $urandom;
         @(negedge CLK);
         exp = model_out();
         checks++;
         if (dut_out() !== exp) $display("FAIL dread_cycle%0d got %h exp %h", c, dut_out(), exp);
         else passes++;
         beat = (dwait == 1'b0);
         if (beat) begin
            zeros++;
            checks++;
            if (ramaddr !== 32'h100 + 32'(4 * (zeros - 1)) || ramREN !== 1'b1)
               $display("FAIL dread_beat_addr got %h exp %h", ramaddr, 32'h100 + 32'(4 * (zeros - 1)));
            else passes++;
         end
         tick();
         if (beat) daddr = daddr + 32'd4;
         if (zeros == 2) dREN = 1'b0;
      end
      checks++;
      if (zeros !== 2) $display("FAIL dread_beat_count got %0d exp 2", zeros);
      else passes++;
      @(negedge CLK);
      checks++;
      if (ramREN !== 1'b0 || dwait !== 1'b1 || iwait !== 1'b1)
         $display("FAIL dread_end_idle got %b%b%b exp 011", ramREN, dwait, iwait);
      else passes++;
      tick();
   endtask

   task automatic test_write_priority();
      outs_t exp;
      idle_inputs();
      iREN = 1'b1; dREN = 1'b1; dWEN = 1'b1;
      daddr = 32'h3100; dstore = 32'hDEADBEEF; iaddr = 32'h40;
      ramstate = ACCESS;
      for (int c = 0; c < 5; c++) begin
         ramload = $urandom;
         @(negedge CLK);
         exp = model_out();
         checks++;
         if (dut_out() !== exp) $display("FAIL wprio_cycle%0d got %h exp %h", c, dut_out(), exp);
         else passes++;
         if (c == 1) begin
            checks++;
            if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramstore !== 32'hDEADBEEF || ramaddr !== 32'h3100)
               $display("FAIL wprio_write got %b%b %h exp 10 deadbeef", ramWEN, ramREN, ramstore);
            else passes++;
         end
         if (c == 3) begin
            checks++;
            if (iwait !== 1'b0 || iload !== ramload || ramaddr !== 32'h40)
               $display("FAIL wprio_ibeat got %b %h exp 0 %h", iwait, iload, ramload);
            else passes++;
         end
         tick();
         if (c == 2) begin dREN = 1'b0; dWEN = 1'b0; end
      end
      idle_inputs();
      apply_reset();
   endtask

   task automatic test_no_interleave();
      outs_t exp;
      idle_inputs();
      iREN = 1'b1;
      for (int c = 0; c < 24; c++) begin
         iaddr    = $urandom;
         daddr    = $urandom;
         ramload  = $urandom;
         ramstate = ($urandom_range(0, 1) == 1) ? ACCESS : BUSY;
         if (c >= 3) dREN = 1'b1;
         @(negedge CLK);
         exp = model_out();
         checks++;
         if (dut_out() !== exp) $display("FAIL interleave_cycle%0d got %h exp %h", c, dut_out(), exp);
         else passes++;
         checks++;
         if (m_owner == 1 && iwait !== 1'b1) $display("FAIL interleave_iwait got %b exp 1", iwait);
         else passes++;
         tick();
      end
      idle_inputs();
      apply_reset();
   endtask

   task automatic test_error();
      outs_t exp;
      idle_inputs();
      dREN = 1'b1; daddr = 32'h200; ramstate = BUSY;
      for (int c = 0; c < 7; c++) begin
         ramstate = (c == 1) ? ERROR : BUSY;
         @(negedge CLK);
         exp = model_out();
         checks++;
         if (dut_out() !== exp) $display("FAIL error_cycle%0d got %h exp %h", c, dut_out(), exp);
         else passes++;
         if (c >= 2) begin
            checks++;
            if (err !== 1'b1 || dwait !== 1'b1) $display("FAIL error_sticky got %b%b exp 11", err, dwait);
            else passes++;
         end
         tick();
      end
      dREN = 1'b0;
      apply_reset();
      @(negedge CLK);
      checks++;
      if (err !== 1'b0) $display("FAIL error_clear got %b exp 0", err);
      else passes++;
      tick();
   endtask

   task automatic test_reset_midburst();
      outs_t exp;
      idle_inputs();
      dREN = 1'b1; daddr = 32'h500; ramstate = ACCESS;
      for (int c = 0; c < 9; c++) begin
         RST = (c == 2);
         ramload = $urandom;
         @(negedge CLK);
         exp = model_out();
         checks++;
         if (dut_out() !== exp) $display("FAIL rstmid_cycle%0d got %h exp %h", c, dut_out(), exp);
         else passes++;
         if (c == 2 || c == 3) begin
            checks++;
            if (ramREN !== 1'b0 || ramWEN !== 1'b0 || err !== 1'b0)
               $display("FAIL rstmid_idle got %b%b%b exp 000", ramREN, ramWEN, err);
            else passes++;
         end
         tick();
      end
      RST = 1'b0;
      idle_inputs();
      apply_reset();
   endtask

   task automatic test_random();
      outs_t exp;
      idle_inputs();
      for (int c = 0; c < 400; c++) begin
         RST      = ($urandom_range(0, 39) == 0);
         iREN     = ($urandom_range(0, 3) != 0);
         dREN     = ($urandom_range(0, 2) == 0);
         dWEN     = ($urandom_range(0, 4) == 0);
         iaddr    = $urandom;
         daddr    = $urandom;
         dstore   = $urandom;
         ramload  = $urandom;
         ramstate = ramstate_t'($urandom_range(0, 3));
         if (ramstate == ERROR && $urandom_range(0, 3) != 0) ramstate = ACCESS;
         @(negedge CLK);
         exp = model_out();
         checks++;
         if (dut_out() !== exp) $display("FAIL random_cycle%0d got %h exp %h", c, dut_out(), exp);
         else passes++;
         tick();
      end
      RST = 1'b0;
   endtask

   initial begin
      RST = 1'b1;
      idle_inputs();
      test_reset();
      test_dread_burst();
      test_write_priority();
      test_no_interleave();
      test_error();
      test_reset_midburst();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/cache_mem_arbiter.md
CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
REQ-001 The block SHALL use one clock and reset as follows: CLK, single clock, all state updates on its rising edge; RST, reset, synchronous and active-high.
REQ-002 The block SHALL have parameter BURST_LEN, default 2, giving the number of data-cache words per block transfer (range 1..4).
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- iREN  in  1  instruction-cache read request
- iaddr  in  32  instruction-cache address
- iwait  out  1  instruction-cache stall; 0 = iload valid this cycle
- iload  out  32  instruction-cache read data
- dREN  in  1  data-cache read request
- dWEN  in  1  data-cache write request
- daddr  in  32  data-cache address
- dstore  in  32  data-cache write data
- dwait  out  1  data-cache stall; 0 = beat complete this cycle
- dload  out  32  data-cache read data
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  RAM status, ramstate_t: FREE, BUSY, ACCESS, ERROR
- err  out  1  sticky error flag

Function
REQ-004 The block SHALL implement a three-state FSM: IDLE, DGRANT, IGRANT.
REQ-005 In IDLE it SHALL drive ramREN=ramWEN=0, ramaddr=ramstore=0, iwait=dwait=1, iload=dload=0.
REQ-006 In IDLE, if dREN or dWEN is asserted, it SHALL move to DGRANT next cycle; otherwise, if iREN is asserted, it SHALL move to IGRANT; otherwise it SHALL stay in IDLE. Arbitration latency is 1 cycle.
REQ-007 In DGRANT it SHALL drive ramaddr=daddr and ramstore=dstore.
REQ-008 In DGRANT it SHALL drive ramWEN=dWEN and ramREN=dREN&~dWEN; when both are asserted, the write wins.
REQ-009 In DGRANT it SHALL drive dload=ramload and dwait=(ramstate!=ACCESS); iwait SHALL stay 1.
REQ-010 A 2-bit beat counter SHALL increment on each DGRANT cycle with ramstate==ACCESS.
REQ-011 The grant SHALL be held across all BURST_LEN beats, so that an icache request cannot interleave inside a dcache block (read or write-back).
REQ-012 On the final-beat ACCESS, the counter SHALL clear and the next state SHALL be IGRANT if iREN is asserted, else IDLE.
REQ-013 If dREN and dWEN are both 0 during DGRANT (request dropped mid-burst), the FSM SHALL return to IDLE next cycle with the counter cleared and no RAM enable asserted that cycle.
REQ-014 In IGRANT it SHALL drive ramREN=iREN, ramaddr=iaddr, iload=ramload, iwait=(ramstate!=ACCESS); dwait SHALL stay 1; ramWEN SHALL be 0.
REQ-015 On IGRANT ACCESS the next state SHALL be DGRANT if dREN or dWEN is asserted, else IGRANT if iREN is asserted, else IDLE. This alternation prevents starvation.
REQ-016 If iREN drops in IGRANT, the FSM SHALL go to IDLE next cycle.
REQ-017 ramstate==BUSY or FREE SHALL keep the owner's wait at 1 with no state change.
REQ-018 ramstate==ERROR SHALL keep wait at 1 and set err=1 next cycle; err is cleared only by reset.
REQ-019 The non-granted requester SHALL always see wait=1 and load=0.
REQ-020 All outputs SHALL be combinational from registered state and current inputs; no RAM enable SHALL be asserted outside a grant state.

Reset
REQ-021 When RST=1 at a clock edge, the FSM SHALL go to IDLE, and the beat counter and err SHALL clear to 0.
REQ-022 During and after reset, outputs SHALL equal the IDLE values of REQ-005.
REQ-023 A reset asserted mid-burst SHALL abandon the burst with no further RAM enables.

Structure
REQ-024 ramstate_t and word_t SHALL come from cpu_types_pkg; the FSM state enum SHALL be local to the module.
REQ-025 No sub-module is required; the beat counter SHALL be inline.

Verification
REQ-026 dREN=1, daddr=0x100, ramstate=ACCESS on alternate cycles -> two beats at 0x100 then 0x104 (dcache steps the address); dwait=0 exactly twice; the FSM then goes to IDLE.
REQ-027 iREN and dWEN asserted together in IDLE -> DGRANT first; after 2 dcache ACCESS beats, IGRANT; iload=ramload with iwait=0 on the next ACCESS.
REQ-028 Continuous iREN plus a dREN arriving during IGRANT -> after one icache beat the grant passes to DGRANT; the icache is never granted mid-dcache-burst.
REQ-029 dREN=1, dWEN=1, daddr=0x3100, dstore=0xDEADBEEF -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF.
REQ-030 ramstate=ERROR for 1 cycle during DGRANT -> dwait=1 and err=1 from the next cycle until RST.
REQ-031 RST=1 after beat 1 of a DGRANT burst -> next cycle IDLE with ramREN=ramWEN=0, counter 0, err 0.
